// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receiver.
package uart_pkg;
  localparam int DATA_BITS            = 8;
  localparam int CLKS_PER_BIT_DEFAULT = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } rx_state_e;
endpackage

// File: rtl/uart_rx_bit_timer.sv
// Bit-period counter: flags the middle of the start bit and the end of each bit period.
module uart_rx_bit_timer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic halfBit,
  output logic fullBit
);
  localparam int CW = $clog2(CLKS_PER_BIT);

  logic [CW-1:0] cnt_q, cnt_d;

  assign halfBit = (cnt_q == CW'(CLKS_PER_BIT / 2 - 1));
  assign fullBit = (cnt_q == CW'(CLKS_PER_BIT - 1));

  // Restarting at fullBit keeps the counter from wrapping past its compare point.
  always_comb begin
    cnt_d = cnt_q;
    if (clear)       cnt_d = '0;
    else if (enable) cnt_d = fullBit ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, framing FSM and sticky status flags.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  input  logic       clrRxDone,
  input  logic       clrRxErr,
  output logic [7:0] rxData,
  output logic       rxDone,
  output logic       frameErr,
  output logic       overrun,
  output logic       rxBusy
);
  rx_state_e                state_q, state_d;
  logic                     meta_q, sync_q;
  logic [DATA_BITS-1:0]     shift_q, shift_d;
  logic [DATA_BITS-1:0]     data_q, data_d;
  logic [2:0]               idx_q, idx_d;
  logic                     done_q, done_d, fe_q, fe_d, ovr_q, ovr_d;
  logic                     bit_clr, bit_en, half_bit, full_bit;
  logic                     done_set, err_set;

  uart_rx_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (bit_clr),
    .enable (bit_en),
    .halfBit(half_bit),
    .fullBit(full_bit)
  );

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    data_d   = data_q;
    idx_d    = idx_q;
    bit_clr  = 1'b0;
    bit_en   = 1'b0;
    done_set = 1'b0;
    err_set  = 1'b0;
    case (state_q)
      IDLE: begin
        bit_clr = 1'b1;
        idx_d   = '0;
        if (!sync_q) state_d = START;
      end
      START: begin
        bit_en = 1'b1;
        if (half_bit) begin
          // Counter restarts here so data samples land mid-bit.
          bit_clr = 1'b1;
          state_d = sync_q ? IDLE : DATA;
        end
      end
      DATA: begin
        bit_en = 1'b1;
        if (full_bit) begin
          shift_d = {sync_q, shift_q[DATA_BITS-1:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'(DATA_BITS - 1)) state_d = STOP;
        end
      end
      STOP: begin
        bit_en = 1'b1;
        if (full_bit) begin
          data_d = shift_q;
          if (sync_q) begin
            done_set = 1'b1;
            state_d  = IDLE;
          end else begin
            err_set = 1'b1;
            state_d = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        bit_clr = 1'b1;
        if (sync_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Set has priority over the clear pulses.
  assign done_d = (done_q & ~clrRxDone) | done_set;
  assign ovr_d  = (ovr_q  & ~clrRxErr)  | (done_set & done_q);
  assign fe_d   = (fe_q   & ~clrRxErr)  | err_set;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q  <= 1'b1;
      sync_q  <= 1'b1;
      state_q <= IDLE;
      shift_q <= '0;
      data_q  <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
      fe_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      meta_q  <= rxd;
      sync_q  <= meta_q;
      state_q <= state_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      fe_q    <= fe_d;
      ovr_q   <= ovr_d;
    end
  end

  assign rxData   = data_q;
  assign rxDone   = done_q;
  assign frameErr = fe_q;
  assign overrun  = ovr_q;
  assign rxBusy   = (state_q != IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: driver pushes expected results, monitor checks on flag events.
module tb_uart_rx;
  localparam int CPB    = 16;
  localparam int LAT_LO = (19 * CPB) / 2 + 2;
  localparam int LAT_HI = (19 * CPB) / 2 + 4;

  logic       clk = 1'b0, rst = 1'b1, rxd = 1'b1, clrRxDone = 1'b0, clrRxErr = 1'b0;
  logic [7:0] rxData;
  logic       rxDone, frameErr, overrun, rxBusy;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .rxd(rxd), .clrRxDone(clrRxDone), .clrRxErr(clrRxErr),
    .rxData(rxData), .rxDone(rxDone), .frameErr(frameErr), .overrun(overrun), .rxBusy(rxBusy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0]  data;
    logic        done, fe, ov;
    int unsigned t0;
  } exp_t;

  exp_t q[$];
  int   checks = 0, errors = 0;

  // Reference model: sticky flags and last byte, updated per frame and per clear pulse.
  logic [7:0] m_data = 8'h00;
  logic       m_done = 1'b0, m_fe = 1'b0, m_ov = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic busy);
    check({tag, ".rxData"},   int'(rxData),   int'(m_data));
    check({tag, ".rxDone"},   int'(rxDone),   int'(m_done));
    check({tag, ".frameErr"}, int'(frameErr), int'(m_fe));
    check({tag, ".overrun"},  int'(overrun),  int'(m_ov));
    check({tag, ".rxBusy"},   int'(rxBusy),   int'(busy));
  endtask

  task automatic pulse(input bit cd, input bit ce);
    clrRxDone = cd;
    clrRxErr  = ce;
    idle(1);
    clrRxDone = 1'b0;
    clrRxErr  = 1'b0;
    if (cd) m_done = 1'b0;
    if (ce) begin
      m_fe = 1'b0;
      m_ov = 1'b0;
    end
  endtask

  // Sends one frame; optional clears are pulsed late in the stop bit, after completion.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit cd, input bit ce);
    exp_t e;
    m_data = b;
    if (stop_ok) begin
      m_ov   = m_ov | m_done;
      m_done = 1'b1;
    end else begin
      m_fe = 1'b1;
    end
    e.data = b; e.done = m_done; e.fe = m_fe; e.ov = m_ov; e.t0 = cyc;
    q.push_back(e);
    rxd = 1'b0;
    idle(CPB);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      idle(CPB);
    end
    rxd = stop_ok;
    idle(CPB / 2 + 6);
    pulse(cd, ce);
    idle(CPB - CPB / 2 - 7);
  endtask

  // Monitor: any rising status flag marks a completed frame.
  logic pd = 1'b0, pf = 1'b0, po = 1'b0;
  exp_t me;
  always @(negedge clk) begin
    if (!rst && ((rxDone && !pd) || (frameErr && !pf) || (overrun && !po))) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: rxData=%0h rxDone=%0b frameErr=%0b overrun=%0b",
                 rxData, rxDone, frameErr, overrun);
      end else begin
        me = q.pop_front();
        check("ev.rxData",   int'(rxData),   int'(me.data));
        check("ev.rxDone",   int'(rxDone),   int'(me.done));
        check("ev.frameErr", int'(frameErr), int'(me.fe));
        check("ev.overrun",  int'(overrun),  int'(me.ov));
        checks++;
        if (int'(cyc - me.t0) < LAT_LO || int'(cyc - me.t0) > LAT_HI) begin
          errors++;
          $display("FAIL ev.latency: got %0d cycles required %0d..%0d",
                   int'(cyc - me.t0), LAT_LO, LAT_HI);
        end
      end
    end
    pd = rxDone;
    pf = frameErr;
    po = overrun;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] b;
    bit ok, cd, ce, nfe, nov;
    idle(4);
    check_all("reset", 1'b0);
    rst = 1'b0;
    idle(10);

    send_frame(8'h05, 1'b1, 1'b0, 1'b0);
    check_all("byte05", 1'b0);
    pulse(1'b1, 1'b0);

    send_frame(8'hA5, 1'b1, 1'b1, 1'b0);
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
    check_all("b2b", 1'b0);
    pulse(1'b1, 1'b0);
    idle(CPB);

    send_frame(8'h11, 1'b1, 1'b0, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0, 1'b0);
    check_all("overrun", 1'b0);
    pulse(1'b0, 1'b1);
    check_all("clr_err_only", 1'b0);
    pulse(1'b1, 1'b0);

    // Bad stop followed by a held break: must park until the line rises.
    send_frame(8'hFF, 1'b0, 1'b0, 1'b0);
    idle(3 * CPB);
    check_all("break", 1'b1);
    rxd = 1'b1;
    idle(4);
    check_all("break_release", 1'b0);
    idle(3 * CPB);
    check_all("no_spurious", 1'b0);
    pulse(1'b0, 1'b1);

    rxd = 1'b0;
    idle(4);
    check("glitch.busy", int'(rxBusy), 1);
    rxd = 1'b1;
    idle(2 * CPB);
    check_all("glitch", 1'b0);

    // Reset in the middle of data bit 3 of 8'h5A.
    b = 8'h5A;
    rxd = 1'b0;
    idle(CPB);
    for (int i = 0; i < 4; i++) begin
      rxd = b[i];
      idle(i == 3 ? CPB / 2 : CPB);
    end
    check("midframe.busy", int'(rxBusy), 1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    rxd = 1'b1;
    m_data = 8'h00; m_done = 1'b0; m_fe = 1'b0; m_ov = 1'b0;
    check_all("after_rst", 1'b0);
    idle(2 * CPB);
    check_all("after_rst_idle", 1'b0);
    send_frame(8'hC3, 1'b1, 1'b0, 1'b0);
    check_all("post_rst_C3", 1'b0);
    pulse(1'b1, 1'b0);

    // Random frames; error flags are cleared whenever set so every completion raises a flag.
    for (int n = 0; n < 16; n++) begin
      b   = 8'($urandom);
      ok  = ($urandom_range(5) != 0);
      cd  = 1'($urandom_range(1));
      nfe = m_fe | !ok;
      nov = m_ov | (ok & m_done);
      ce  = nfe | nov;
      send_frame(b, ok, cd, ce);
      if (!ok) begin
        rxd = 1'b1;
        idle(CPB);
      end else if ($urandom_range(1) == 1) begin
        idle(int'($urandom_range(1, 2 * CPB)));
      end
      if (!ok || n % 4 == 0) check_all("rand", 1'b0);
    end

    idle(2 * CPB);
    check("queue_empty", q.size(), 0);
    check_all("final", 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
